// File: rtl/spi_slave_byte_pkg.sv
// Shared definitions for the SPI byte slave: FSM state encoding and byte width.
package spi_slave_byte_pkg;

    localparam int SPI_BYTE_W = 8;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } spi_state_t;

endpackage

// File: rtl/spi_sync.sv
// Multi-flop synchronizer for one asynchronous SPI pin; reset loads the pin's idle level.
module spi_sync #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RESET_VAL   = 1'b0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_d,
    output logic o_q
);

    logic [SYNC_STAGES-1:0] r_chain;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_chain <= {SYNC_STAGES{RESET_VAL}};
        end else begin
            r_chain <= {r_chain[SYNC_STAGES-2:0], i_d};
        end
    end

    assign o_q = r_chain[SYNC_STAGES-1];

endmodule

// File: rtl/spi_slave_byte.sv
// SPI mode-0 byte slave: oversamples sclk/mosi/nss in the clk domain, receives bytes on
// sclk rises and shifts tx data out on sclk falls.
module spi_slave_byte
    import spi_slave_byte_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter bit MSB_FIRST   = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  sclk,
    input  logic                  mosi,
    input  logic                  nss,
    input  logic [SPI_BYTE_W-1:0] tx_data,
    output logic                  miso,
    output logic                  miso_oe,
    output logic [SPI_BYTE_W-1:0] spibus,
    output logic                  stsourcevalid,
    output logic                  nss_s,
    output logic                  tx_load,
    output logic                  frame_err
);

    logic w_sclk_s;
    logic w_mosi_s;
    logic w_nss_s;
    logic r_sclk_d;
    logic r_nss_d;

    spi_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
        .clk(clk), .reset_n(reset_n), .i_d(sclk), .o_q(w_sclk_s)
    );
    spi_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
        .clk(clk), .reset_n(reset_n), .i_d(mosi), .o_q(w_mosi_s)
    );
    spi_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_nss (
        .clk(clk), .reset_n(reset_n), .i_d(nss), .o_q(w_nss_s)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sclk_d <= 1'b0;
            r_nss_d  <= 1'b1;
        end else begin
            r_sclk_d <= w_sclk_s;
            r_nss_d  <= w_nss_s;
        end
    end

    logic w_sclk_rise;
    logic w_sclk_fall;
    logic w_nss_fall;
    logic w_nss_rise;

    assign w_sclk_rise = w_sclk_s & ~r_sclk_d;
    assign w_sclk_fall = ~w_sclk_s & r_sclk_d;
    assign w_nss_fall  = ~w_nss_s & r_nss_d;
    assign w_nss_rise  = w_nss_s & ~r_nss_d;

    spi_state_t r_state;
    spi_state_t w_state_next;
    logic       w_start;
    logic       w_stop;
    logic       w_shift_in;
    logic       w_shift_out;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // An nss rise ends the frame and masks any sclk edge seen in the same cycle.
    always_comb begin
        w_state_next = r_state;
        w_start      = 1'b0;
        w_stop       = 1'b0;
        w_shift_in   = 1'b0;
        w_shift_out  = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_nss_fall) begin
                    w_state_next = ACTIVE;
                    w_start      = 1'b1;
                end
            end
            ACTIVE: begin
                if (w_nss_rise) begin
                    w_state_next = IDLE;
                    w_stop       = 1'b1;
                end else begin
                    w_shift_in  = w_sclk_rise;
                    w_shift_out = w_sclk_fall;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    logic [2:0]            r_bit_cnt;
    logic [SPI_BYTE_W-1:0] r_rx;
    logic [SPI_BYTE_W-1:0] r_tx;
    logic [SPI_BYTE_W-1:0] r_spibus;
    logic                  r_byte_done;
    logic                  r_reload;
    logic                  r_valid;
    logic                  r_tx_load;
    logic                  r_frame_err;
    logic [SPI_BYTE_W-1:0] w_rx_next;
    logic [SPI_BYTE_W-1:0] w_tx_next;

    assign w_rx_next = MSB_FIRST ? {r_rx[SPI_BYTE_W-2:0], w_mosi_s}
                                 : {w_mosi_s, r_rx[SPI_BYTE_W-1:1]};
    assign w_tx_next = MSB_FIRST ? {r_tx[SPI_BYTE_W-2:0], 1'b0}
                                 : {1'b0, r_tx[SPI_BYTE_W-1:1]};

    // The completed byte is published one cycle after its last bit lands, so a frame
    // ending right after bit 8 still delivers it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_bit_cnt   <= '0;
            r_rx        <= '0;
            r_tx        <= '0;
            r_spibus    <= '0;
            r_byte_done <= 1'b0;
            r_reload    <= 1'b0;
            r_valid     <= 1'b0;
            r_tx_load   <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_valid     <= r_byte_done;
            r_byte_done <= 1'b0;
            r_tx_load   <= 1'b0;
            r_frame_err <= 1'b0;
            if (r_byte_done) begin
                r_spibus <= r_rx;
            end
            if (w_start) begin
                r_bit_cnt <= '0;
                r_rx      <= '0;
                r_tx      <= tx_data;
                r_tx_load <= 1'b1;
                r_reload  <= 1'b0;
            end else if (w_stop) begin
                r_frame_err <= (r_bit_cnt != 3'd0);
                r_reload    <= 1'b0;
            end else begin
                if (w_shift_in) begin
                    r_rx      <= w_rx_next;
                    r_bit_cnt <= r_bit_cnt + 3'd1;
                    if (r_bit_cnt == 3'd7) begin
                        r_byte_done <= 1'b1;
                        r_reload    <= 1'b1;
                    end
                end
                if (w_shift_out) begin
                    if (r_reload) begin
                        r_tx      <= tx_data;
                        r_tx_load <= 1'b1;
                        r_reload  <= 1'b0;
                    end else begin
                        r_tx <= w_tx_next;
                    end
                end
            end
        end
    end

    assign miso          = (r_state == ACTIVE) ? (MSB_FIRST ? r_tx[SPI_BYTE_W-1] : r_tx[0]) : 1'b0;
    assign miso_oe       = ~w_nss_s;
    assign nss_s         = w_nss_s;
    assign spibus        = r_spibus;
    assign stsourcevalid = r_valid;
    assign tx_load       = r_tx_load;
    assign frame_err     = r_frame_err;

endmodule

// File: tb/tb_spi_slave_byte.sv
// Directed bench for spi_slave_byte: a default MSB-first instance plus an LSB-first,
// 3-stage instance sharing the same SPI pins for the 4:1 latency case.
module tb_spi_slave_byte;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       sclk = 1'b0;
    logic       mosi = 1'b0;
    logic       nss = 1'b1;
    logic [7:0] txData = 8'h00;

    logic       miso, misoOe, valid, nssS, txLoad, frameErr;
    logic [7:0] spibus;
    logic       misoLsb, misoOeLsb, validLsb, nssSLsb, txLoadLsb, frameErrLsb;
    logic [7:0] spibusLsb;

    spi_slave_byte dut (
        .clk(clk), .reset_n(reset_n), .sclk(sclk), .mosi(mosi), .nss(nss),
        .tx_data(txData), .miso(miso), .miso_oe(misoOe), .spibus(spibus),
        .stsourcevalid(valid), .nss_s(nssS), .tx_load(txLoad), .frame_err(frameErr)
    );

    spi_slave_byte #(.SYNC_STAGES(3), .MSB_FIRST(1'b0)) dutLsb (
        .clk(clk), .reset_n(reset_n), .sclk(sclk), .mosi(mosi), .nss(nss),
        .tx_data(txData), .miso(misoLsb), .miso_oe(misoOeLsb), .spibus(spibusLsb),
        .stsourcevalid(validLsb), .nss_s(nssSLsb), .tx_load(txLoadLsb), .frame_err(frameErrLsb)
    );

    always #5 clk = ~clk;

    int vectorCount = 0;
    int missCount = 0;
    int validTotal = 0;
    int frameErrTotal = 0;
    int txLoadTotal = 0;
    int validTotalLsb = 0;

    // Pulse counters run for the whole simulation; tests compare against snapshots.
    always @(negedge clk) begin
        if (valid) validTotal++;
        if (frameErr) frameErrTotal++;
        if (txLoad) txLoadTotal++;
        if (validLsb) validTotalLsb++;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        vectorCount++;
        if (actual !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic waitClk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic frameStart(input logic [7:0] tx);
        @(negedge clk);
        txData = tx;
        nss = 1'b0;
        waitClk(8);
    endtask

    // Each bit: sclk falls (slave shifts miso), mosi set up, then sclk rises (both sides sample).
    task automatic applyStimulus(input logic [7:0] data, input int nbits, input int half,
                                 output logic [7:0] misoCap);
        misoCap = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            sclk = 1'b0;
            mosi = data[7-i];
            waitClk(half);
            misoCap = {misoCap[6:0], miso};
            sclk = 1'b1;
            waitClk(half);
        end
    endtask

    task automatic frameEnd(input int half);
        sclk = 1'b0;
        waitClk(half);
        nss = 1'b1;
        waitClk(8);
    endtask

    initial begin
        logic [7:0] cap1;
        logic [7:0] cap2;
        int vBase, fBase, tBase, vBaseLsb;

        // Reset state
        waitClk(3);
        checkOutput("rst_spibus", {24'h0, spibus}, 32'h00);
        checkOutput("rst_valid", {31'h0, valid}, 32'h0);
        checkOutput("rst_txload", {31'h0, txLoad}, 32'h0);
        checkOutput("rst_frameerr", {31'h0, frameErr}, 32'h0);
        checkOutput("rst_miso", {31'h0, miso}, 32'h0);
        checkOutput("rst_misooe", {31'h0, misoOe}, 32'h0);
        checkOutput("rst_nss_s", {31'h0, nssS}, 32'h1);
        reset_n = 1'b1;
        waitClk(4);
        checkOutput("post_rst_nss_s", {31'h0, nssS}, 32'h1);

        // Single byte A5
        vBase = validTotal; fBase = frameErrTotal;
        frameStart(8'h00);
        checkOutput("active_misooe", {31'h0, misoOe}, 32'h1);
        applyStimulus(8'hA5, 8, 4, cap1);
        frameEnd(4);
        checkOutput("a5_spibus", {24'h0, spibus}, 32'hA5);
        checkOutput("a5_valid_count", validTotal - vBase, 1);
        checkOutput("a5_frameerr_count", frameErrTotal - fBase, 0);

        // Back-to-back 12, 34
        vBase = validTotal;
        frameStart(8'h00);
        applyStimulus(8'h12, 8, 4, cap1);
        waitClk(2);
        checkOutput("b2b_first_spibus", {24'h0, spibus}, 32'h12);
        applyStimulus(8'h34, 8, 4, cap1);
        frameEnd(4);
        checkOutput("b2b_second_spibus", {24'h0, spibus}, 32'h34);
        checkOutput("b2b_valid_count", validTotal - vBase, 2);

        // miso: 3C then C3 with reload between bytes
        tBase = txLoadTotal;
        frameStart(8'h3C);
        applyStimulus(8'h66, 8, 4, cap1);
        txData = 8'hC3;
        applyStimulus(8'h99, 8, 4, cap2);
        checkOutput("miso_byte1", {24'h0, cap1}, 32'h3C);
        checkOutput("miso_byte2", {24'h0, cap2}, 32'hC3);
        checkOutput("txload_count", txLoadTotal - tBase, 2);
        frameEnd(4);
        checkOutput("idle_miso", {31'h0, miso}, 32'h0);

        // Partial frame of 5 bits, then full FF
        vBase = validTotal; fBase = frameErrTotal;
        frameStart(8'h00);
        applyStimulus(8'hFF, 5, 4, cap1);
        frameEnd(4);
        checkOutput("partial_frameerr", frameErrTotal - fBase, 1);
        checkOutput("partial_no_valid", validTotal - vBase, 0);
        checkOutput("partial_spibus_held", {24'h0, spibus}, 32'h99);
        vBase = validTotal;
        frameStart(8'h00);
        applyStimulus(8'hFF, 8, 4, cap1);
        frameEnd(4);
        checkOutput("ff_spibus", {24'h0, spibus}, 32'hFF);
        checkOutput("ff_valid_count", validTotal - vBase, 1);
        checkOutput("ff_frameerr_total", frameErrTotal - fBase, 1);

        // Reset mid-byte after 3 bits of 5A
        vBase = validTotal; fBase = frameErrTotal;
        frameStart(8'h00);
        applyStimulus(8'h5A, 3, 4, cap1);
        @(negedge clk);
        reset_n = 1'b0;
        sclk = 1'b0;
        nss = 1'b1;
        waitClk(2);
        checkOutput("midrst_spibus", {24'h0, spibus}, 32'h00);
        checkOutput("midrst_misooe", {31'h0, misoOe}, 32'h0);
        checkOutput("midrst_miso", {31'h0, miso}, 32'h0);
        checkOutput("midrst_nss_s", {31'h0, nssS}, 32'h1);
        reset_n = 1'b1;
        waitClk(10);
        checkOutput("midrst_no_frameerr", frameErrTotal - fBase, 0);
        checkOutput("midrst_no_valid", validTotal - vBase, 0);
        vBase = validTotal;
        frameStart(8'h00);
        applyStimulus(8'h5A, 8, 4, cap1);
        frameEnd(4);
        checkOutput("after_rst_spibus", {24'h0, spibus}, 32'h5A);
        checkOutput("after_rst_valid_count", validTotal - vBase, 1);

        // LSB-first, 3 sync stages, clk:sclk = 4:1; wire order of 01 is 1,0,0,0,0,0,0,0
        vBaseLsb = validTotalLsb;
        frameStart(8'h00);
        applyStimulus(8'h80, 7, 2, cap1);
        sclk = 1'b0;
        mosi = 1'b0;
        waitClk(2);
        sclk = 1'b1;
        @(posedge clk);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("lsb_latency_early", {31'h0, validLsb}, 32'h0);
        @(posedge clk);
        #1;
        checkOutput("lsb_latency_edge4", {31'h0, validLsb}, 32'h1);
        @(posedge clk);
        #1;
        checkOutput("lsb_pulse_width", {31'h0, validLsb}, 32'h0);
        frameEnd(2);
        checkOutput("lsb_spibus", {24'h0, spibusLsb}, 32'h01);
        checkOutput("lsb_valid_count", validTotalLsb - vBaseLsb, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule

// File: doc/spi_slave_byte.md
SPI_SLAVE_BYTE -- requirements
Module: spi_slave_byte

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2: synchronizer depth on sclk/mosi/nss; legal range 2..3.
REQ-002 SHALL have parameter MSB_FIRST, default 1: 1 = MSB first on both mosi and miso; 0 = LSB first.
REQ-003 SHALL have port clk  input  1: system clock; all logic on its rising edge.
REQ-004 SHALL have port reset_n  input  1: asynchronous, active-low reset.
REQ-005 SHALL have port sclk  input  1: SPI clock from the master, asynchronous to clk, mode 0 (CPOL=0, CPHA=0).
REQ-006 SHALL have port mosi  input  1: serial data from the master, asynchronous.
REQ-007 SHALL have port nss  input  1: slave select, active-low, asynchronous.
REQ-008 SHALL have port tx_data  input  8: byte to shift out on miso; sampled only on tx_load.
REQ-009 SHALL have port miso  output  1: serial data to the master.
REQ-010 SHALL have port miso_oe  output  1: miso drive enable, 1 while nss_s is low.
REQ-011 SHALL have port spibus  output  8: last fully received byte.
REQ-012 SHALL have port stsourcevalid  output  1: one-clk pulse marking a new spibus byte.
REQ-013 SHALL have port nss_s  output  1: synchronized nss, for use by the downstream frame parser.
REQ-014 SHALL have port tx_load  output  1: one-clk pulse in the cycle tx_data is captured.
REQ-015 SHALL have port frame_err  output  1: one-clk pulse when a frame ends on a partial byte.

Function
REQ-016 SHALL pass sclk, mosi and nss each through a SYNC_STAGES flop chain and detect sclk rise/fall from the synchronized value and a one-cycle-delayed copy.
REQ-017 SHALL require clk >= 4x sclk; behaviour at lower ratios is undefined.
REQ-018 SHALL implement two states: IDLE (nss_s high) and ACTIVE (nss_s low).
REQ-019 IDLE->ACTIVE on nss_s fall: clear bit counter and rx shift register, capture tx_data into the tx shift register, pulse tx_load.
REQ-020 ACTIVE->IDLE on nss_s rise, taking priority over any sclk edge detected in the same cycle.
REQ-021 In ACTIVE, on each sclk rise: shift mosi into the rx register and increment the 3-bit bit counter, which wraps 7->0.
REQ-022 On the sclk rise that completes bit 8: load spibus with the full byte and assert stsourcevalid for exactly one clk cycle.
REQ-023 stsourcevalid SHALL rise exactly SYNC_STAGES+1 clk edges after the first clk edge that samples the 8th sclk rise high.
REQ-024 spibus SHALL hold its value until the next complete byte.
REQ-025 In ACTIVE, on each sclk fall: advance the tx shift register by one bit.
REQ-026 On the sclk fall following a byte completion: reload the tx shift register from tx_data and pulse tx_load, instead of shifting.
REQ-027 miso SHALL present tx_shift[7] (MSB_FIRST=1) or tx_shift[0] (MSB_FIRST=0) while ACTIVE, and 0 in IDLE.
REQ-028 When nss_s rises with bit counter != 0: discard the partial byte, pulse frame_err for one cycle, leave spibus unchanged and do not assert stsourcevalid.
REQ-029 Back-to-back bytes within one frame SHALL each produce exactly one stsourcevalid pulse, with no gap cycles required between bytes.

Reset
REQ-030 Asserting reset_n low SHALL immediately force state=IDLE, bit counter=0, shift registers=0, spibus=8'h00, stsourcevalid=0, tx_load=0, frame_err=0, miso=0 and miso_oe=0.
REQ-031 Asserting reset_n low SHALL load all synchronizer flops with their idle level (sclk 0, mosi 0, nss 1), so that nss_s=1 out of reset.
REQ-032 Reset asserted mid-byte SHALL drop the partial byte silently, with no frame_err.
REQ-033 Reset SHALL start no transfer until a fresh nss fall is seen after reset release.

Structure
REQ-034 A shared package SHALL hold the state encoding (IDLE=1'b0, ACTIVE=1'b1) and the constant SPI_BYTE_W=8.
REQ-035 The synchronizer SHALL be one sub-module, spi_sync (parameters SYNC_STAGES and reset value), instantiated three times.

Verification
REQ-036 Frame nss low, byte 8'hA5, nss high -> spibus=8'hA5, exactly one stsourcevalid pulse, frame_err never asserted.
REQ-037 One frame carrying 8'h12 then 8'h34 back-to-back -> two stsourcevalid pulses, with spibus 8'h12 then 8'h34.
REQ-038 tx_data=8'h3C at nss fall, then 8'hC3 before byte 2 -> miso bits 0,0,1,1,1,1,0,0 then 1,1,0,0,0,0,1,1 sampled on sclk rises; tx_load pulses twice.
REQ-039 nss raised after 5 bits, then a full frame carrying 8'hFF -> one frame_err pulse, no stsourcevalid for the partial byte, then spibus=8'hFF.
REQ-040 reset_n pulsed low after 3 bits of 8'h5A -> all outputs at reset values, no frame_err; the next full frame carrying 8'h5A yields spibus=8'h5A.
REQ-041 clk:sclk = 4:1 with SYNC_STAGES=3 and MSB_FIRST=0, byte 8'h01 sent LSB first -> spibus=8'h01, stsourcevalid latency exactly 4 clk edges.
